fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the instruction word width.
REQ-002 The block SHALL have parameter OP_W, default 3, meaning the opcode field width; the address/operand width is WORD_W-OP_W (5 by default).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, with the rising edge active.
REQ-004 The block SHALL have port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Iaddress, output, WORD_W-OP_W bits: the instruction memory address, always equal to PC.
REQ-006 The block SHALL have port Idata, input, WORD_W bits: the instruction word, combinationally valid for Iaddress in the same cycle.
REQ-007 The block SHALL have port z_flag, input, 1 bit: datapath zero flag from the last arithmetic operation.
REQ-008 The block SHALL have port op_valid, output, 1 bit: the issued instruction is valid.
REQ-009 The block SHALL have port op_ready, input, 1 bit: the datapath accepts the issued instruction.
REQ-010 The block SHALL have port opcode, output, OP_W bits: IR[WORD_W-1 -: OP_W].
REQ-011 The block SHALL have port operand, output, WORD_W-OP_W bits: IR[WORD_W-OP_W-1:0].
REQ-012 The block SHALL have port halted, output, 1 bit: the sequencer is stopped; driven 0 when FETCH_HALT_EN is undefined.

Function
REQ-013 The block SHALL contain PC (WORD_W-OP_W bits), IR (WORD_W bits) and a state register with states FETCH, DECODE, ISSUE and HALT.
REQ-014 FETCH SHALL take one cycle: IR <= Idata, PC <= PC+1 modulo 2^(WORD_W-OP_W) (31 wraps to 0), then go to DECODE.
REQ-015 DECODE with opcode BNE SHALL sample z_flag: if 0, PC <= operand; if 1, PC is unchanged; then go to FETCH; BNE is never issued (op_valid stays 0).
REQ-016 DECODE with any other opcode SHALL go to ISSUE, subject to REQ-026.
REQ-017 In ISSUE, op_valid SHALL be 1 combinationally from state, and opcode/operand SHALL remain stable until the cycle in which op_ready=1.
REQ-018 Transfer SHALL occur on a rising edge with op_valid=1 and op_ready=1; the next state SHALL be FETCH.
REQ-019 op_ready SHALL be ignored outside ISSUE.
REQ-020 op_ready=1 in the first ISSUE cycle SHALL complete the transfer in that cycle (zero wait).
REQ-021 Latency SHALL be: non-branch instruction 3 cycles minimum (FETCH, DECODE, ISSUE) plus one per op_ready-low ISSUE cycle; BNE 2 cycles.
REQ-022 A branch target equal to the BNE's own address SHALL loop while z_flag=0; there is no special case.
REQ-023 Iaddress SHALL equal PC in every state, including reset.

Reset
REQ-024 n_reset=0 SHALL immediately (asynchronously) force PC=0, IR=0 and state=FETCH, giving op_valid=0, opcode=0, operand=0, halted=0 and Iaddress=0.
REQ-025 Reset asserted mid-ISSUE SHALL drop op_valid without a transfer; after release the first fetch SHALL be from address 0 on the first rising edge.

Configuration
REQ-026 Macro FETCH_HALT_EN defined: an all-zero IR in DECODE SHALL go to HALT, with halted=1, op_valid=0, PC frozen, and exit only by reset.
REQ-027 FETCH_HALT_EN undefined: the HALT state SHALL be absent, an all-zero word SHALL be issued as a normal instruction, and halted SHALL be tied 0.

Verification
REQ-028 Reset then release with op_ready=1 and a program of STORE 30, LOAD 30, ADD 31, STORE 30 at addresses 0-3: Iaddress SHALL step 0,1,2,3, with op_valid pulsing once per 3 cycles and opcode/operand matching each word.
REQ-029 BNE 1 at address 4 with z_flag=0: after 2 cycles Iaddress=1 with no op_valid pulse; with z_flag=1, Iaddress=5.
REQ-030 op_ready held 0 for 4 ISSUE cycles on ADD 31: op_valid=1 and opcode/operand SHALL be stable for 5 cycles, with a single transfer and PC unchanged until FETCH.
REQ-031 PC=31 with a non-branch word: after FETCH, Iaddress=0 (wrap).
REQ-032 n_reset pulsed low during ISSUE: op_valid SHALL be 0 in the same cycle, with IR=0 and Iaddress=0; the next fetch SHALL be from address 0.
REQ-033 With FETCH_HALT_EN, word 0 at address 5: halted=1 by the end of DECODE, with Iaddress=6 held and no op_valid; without the macro, op_valid asserts with opcode=0 and operand=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch/decode/issue sequencer with valid/ready issue port; BNE (opcode 3'b100) resolved in DECODE.
// Optional FETCH_HALT_EN: an all-zero instruction word halts the sequencer until reset.
module fetch_ctrl #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                     clock,
    input  logic                     n_reset,
    output logic [WORD_W-OP_W-1:0]   Iaddress,
    input  logic [WORD_W-1:0]        Idata,
    input  logic                     z_flag,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [OP_W-1:0]          opcode,
    output logic [WORD_W-OP_W-1:0]   operand,
    output logic                     halted
);
    localparam logic [OP_W-1:0] BNE_OP = OP_W'(4);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {FETCH, DECODE, ISSUE, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH, DECODE, ISSUE} state_t;
`endif

    state_t                  r_state;
    logic [WORD_W-OP_W-1:0]  r_pc;
    logic [WORD_W-1:0]       r_ir;

    assign Iaddress = r_pc;
    assign opcode   = r_ir[WORD_W-1 -: OP_W];
    assign operand  = r_ir[WORD_W-OP_W-1:0];
    assign op_valid = (r_state == ISSUE);
`ifdef FETCH_HALT_EN
    assign halted   = (r_state == HALT);
`else
    assign halted   = 1'b0;
`endif

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir    <= Idata;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= DECODE;
                end
                DECODE: begin
                    // Branches never reach ISSUE; a not-taken BNE leaves PC at the fall-through address.
                    if (opcode == BNE_OP) begin
                        if (!z_flag)
                            r_pc <= operand;
                        r_state <= FETCH;
                    end
`ifdef FETCH_HALT_EN
                    else if (r_ir == '0)
                        r_state <= HALT;
`endif
                    else
                        r_state <= ISSUE;
                end
                ISSUE: begin
                    if (op_ready)
                        r_state <= FETCH;
                end
                default: r_state <= r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized self-checking bench; an instruction-level model predicts addresses, issues and transfers.
module tb_fetch_ctrl;
    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int A      = WORD_W - OP_W;
    localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, ADD = 3'd2, BNE = 3'd4;

    logic              clock = 1'b0;
    logic              n_reset = 1'b0;
    logic              z_flag = 1'b0;
    logic              op_ready = 1'b0;
    logic              op_valid, halted;
    logic [A-1:0]      Iaddress, operand;
    logic [OP_W-1:0]   opcode;
    logic [WORD_W-1:0] Idata;
    logic [WORD_W-1:0] mem [32];
    logic [A-1:0]      pc_m;
    int errors = 0, checks = 0, xfers = 0, exp_xfers = 0;

    always #5 clock = ~clock;
    assign Idata = mem[Iaddress];

    fetch_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clock(clock), .n_reset(n_reset), .Iaddress(Iaddress), .Idata(Idata),
        .z_flag(z_flag), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .halted(halted)
    );

    always @(posedge clock)
        if (n_reset && op_valid && op_ready) xfers <= xfers + 1;

    task automatic do_reset();
        @(negedge clock);
        n_reset = 1'b0;
        #1;
        checks++;
        if ({Iaddress, op_valid, opcode, operand, halted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d valid=%b op=%0d opnd=%0d halted=%b want all 0",
                     Iaddress, op_valid, opcode, operand, halted);
        end
        #1 n_reset = 1'b1;
        pc_m = '0;
    endtask

    // Runs one instruction from FETCH; w = number of op_ready-low ISSUE cycles.
    task automatic run_instr(input logic z, input int w);
        logic [WORD_W-1:0] word;
        logic [A-1:0]      nxt;
        word = mem[pc_m];
        nxt  = pc_m + 1'b1;
        checks++;
        if (Iaddress !== pc_m || op_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_state: got addr=%0d valid=%b want addr=%0d valid=0", Iaddress, op_valid, pc_m);
        end
        z_flag   = z;
        op_ready = 1'($urandom);
        @(posedge clock); #1;
        checks++;
        if (Iaddress !== nxt || op_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL decode_state: got addr=%0d valid=%b halted=%b want addr=%0d valid=0 halted=0",
                     Iaddress, op_valid, halted, nxt);
        end
        op_ready = 1'($urandom);
        if (word[7:5] == BNE) begin
            pc_m = z ? nxt : word[4:0];
            @(posedge clock); #1;
            checks++;
            if (Iaddress !== pc_m || op_valid !== 1'b0) begin
                errors++;
                $display("FAIL branch_target: got addr=%0d valid=%b want addr=%0d valid=0", Iaddress, op_valid, pc_m);
            end
        end else begin
            pc_m = nxt;
            for (int i = 0; i <= w; i++) begin
                @(posedge clock); #1;
                checks++;
                if (op_valid !== 1'b1 || opcode !== word[7:5] || operand !== word[4:0] || Iaddress !== pc_m) begin
                    errors++;
                    $display("FAIL issue_cycle%0d: got valid=%b op=%0d opnd=%0d addr=%0d want valid=1 op=%0d opnd=%0d addr=%0d",
                             i, op_valid, opcode, operand, Iaddress, word[7:5], word[4:0], pc_m);
                end
                op_ready = (i == w);
            end
            exp_xfers++;
            @(posedge clock); #1;
            op_ready = 1'b0;
            checks++;
            if (op_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_transfer: got valid=%b want 0", op_valid);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({Iaddress, op_valid, opcode, operand, halted} !== '0) begin
            errors++;
            $display("FAIL power_on_reset: got addr=%0d valid=%b op=%0d opnd=%0d want all 0", Iaddress, op_valid, opcode, operand);
        end
        do_reset();
    endtask

    task automatic test_program();
        do_reset();
        mem[0] = {STORE, 5'd30};
        mem[1] = {LOAD,  5'd30};
        mem[2] = {ADD,   5'd31};
        mem[3] = {STORE, 5'd30};
        for (int i = 0; i < 4; i++) run_instr(1'b0, 0);
    endtask

    task automatic test_branch();
        do_reset();
        mem[0] = {BNE, 5'd4};
        mem[4] = {BNE, 5'd1};
        mem[1] = {BNE, 5'd4};
        mem[5] = {LOAD, 5'd7};
        run_instr(1'b0, 0);
        run_instr(1'b0, 0);
        run_instr(1'b0, 0);
        run_instr(1'b1, 0);
        run_instr(1'b0, 0);
    endtask

    task automatic test_wait();
        do_reset();
        mem[0] = {ADD, 5'd31};
        run_instr(1'b0, 4);
    endtask

    task automatic test_wrap();
        do_reset();
        mem[0]  = {BNE, 5'd31};
        mem[31] = {LOAD, 5'd5};
        run_instr(1'b0, 0);
        run_instr(1'b0, 1);
    endtask

    task automatic test_reset_issue();
        do_reset();
        mem[0] = {ADD, 5'd31};
        op_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (op_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_before_reset: got valid=%b want 1", op_valid);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({Iaddress, op_valid, opcode, operand} !== '0) begin
            errors++;
            $display("FAIL reset_mid_issue: got addr=%0d valid=%b op=%0d opnd=%0d want all 0", Iaddress, op_valid, opcode, operand);
        end
        n_reset = 1'b1;
        pc_m = '0;
        mem[0] = {STORE, 5'd9};
        run_instr(1'b0, 0);
    endtask

    task automatic test_zero_word();
        do_reset();
        mem[0] = {BNE, 5'd5};
        mem[5] = 8'h00;
        run_instr(1'b0, 0);
`ifdef FETCH_HALT_EN
        @(posedge clock); #1;
        @(posedge clock); #1;
        repeat (2) begin
            checks++;
            if (halted !== 1'b1 || Iaddress !== 5'd6 || op_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_state: got halted=%b addr=%0d valid=%b want halted=1 addr=6 valid=0", halted, Iaddress, op_valid);
            end
            repeat (3) @(posedge clock);
            #1;
        end
`else
        run_instr(1'b0, 1);
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i] == 8'h00) mem[i] = {STORE, 5'(i)};
        end
        repeat (150) run_instr(1'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        test_reset();
        test_program();
        test_branch();
        test_wait();
        test_wrap();
        test_reset_issue();
        test_zero_word();
        test_random();
        @(negedge clock);
        checks++;
        if (xfers !== exp_xfers) begin
            errors++;
            $display("FAIL transfer_count: got %0d want %0d", xfers, exp_xfers);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
